// File: rtl/apb_arb_pkg.sv
// Shared APB arbiter definitions: state encoding, default bus widths and the ACCESS wait limit.
// The AW/DW defaults are also used by the existing APB master and slave.
package apb_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam int APB_AW          = 32;
  localparam int APB_DW          = 32;
  localparam int APB_TIMEOUT_CYC = 16;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_SETUP  = ST_SETUP,
    S_ACCESS = ST_ACCESS
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request scanning upward from ptr+1, wrapping mod NREQ.
// Purely combinational; the caller owns and updates the pointer.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        found                          = 1'b1;
        gnt[(int'(ptr) + k) % NREQ]    = 1'b1;
        idx                            = IW'((int'(ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master port among NREQ requesters with round-robin arbitration; 2 cycles minimum per transfer.
// req_ready is a combinational one-hot accept in IDLE or the completing ACCESS cycle; pready stalls ACCESS.
// Optional ACCESS timeout abort is enabled by defining APB_TIMEOUT_EN.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int AW          = APB_AW,
  parameter int DW          = APB_DW,
  parameter int TIMEOUT_CYC = APB_TIMEOUT_CYC
) (
  input  logic               pclk,
  input  logic               prst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [AW-1:0]      paddr,
  output logic [DW-1:0]      pwdata,
  input  logic [DW-1:0]      prdata,
  input  logic               pready,
  input  logic               pslverr
);

  localparam int IW = $clog2(NREQ);

  state_e            state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [AW-1:0]     paddr_q, paddr_d;
  logic [DW-1:0]     pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              arb_en;
  logic [NREQ-1:0]   gnt;
  logic [IW-1:0]     gnt_idx;

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0]     cnt_q, cnt_d;
`endif

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    arb_en      = 1'b0;
`ifdef APB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      S_IDLE:  arb_en = 1'b1;
      S_SETUP: begin
        state_d = S_ACCESS;
`ifdef APB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_ACCESS: begin
        if (pready) begin
          rsp_valid_d = NREQ'(1) << owner_q;
          if (!pwrite_q) rsp_rdata_d = prdata;
          rsp_err_d   = pslverr;
          state_d     = S_IDLE;
          arb_en      = 1'b1;
        end
`ifdef APB_TIMEOUT_EN
        // Abort on the TIMEOUT_CYC-th stalled cycle; no back-to-back grant here.
        else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          rsp_valid_d = NREQ'(1) << owner_q;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    if (arb_en && |req_valid) begin
      state_d  = S_SETUP;
      owner_d  = gnt_idx;
      rr_ptr_d = gnt_idx;
      paddr_d  = req_addr[gnt_idx*AW +: AW];
      pwdata_d = req_wdata[gnt_idx*DW +: DW];
      pwrite_d = req_write[gnt_idx];
    end
  end

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= IW'(NREQ - 1);
      owner_q     <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef APB_TIMEOUT_EN
  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

  assign req_ready = arb_en ? gnt : '0;
  assign psel      = (state_q != S_IDLE);
  assign penable   = (state_q == S_ACCESS);
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: table of single transfers plus round-robin, reset and timeout sequences.
module tb_apb_req_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic               pclk = 1'b0;
  logic               prst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;
  logic               psel, penable, pwrite;
  logic [AW-1:0]      paddr;
  logic [DW-1:0]      pwdata;
  logic [DW-1:0]      prdata;
  logic               pready, pslverr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 pclk = ~pclk;

  apb_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .pclk(pclk), .prst(prst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct {
    int          req;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prd;
    int          waits;
    logic        slverr;
    logic [3:0]  exp_vld;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_xfer(input vec_t v);
    @(negedge pclk);
    req_valid = NREQ'(1) << v.req;
    req_write[v.req] = v.wr;
    req_addr[v.req*AW +: AW] = v.addr;
    req_wdata[v.req*DW +: DW] = v.wdata;
    #1 chk("req_ready_idle", 64'(req_ready), 64'(NREQ'(1) << v.req));
    @(negedge pclk);
    req_valid = '0;
    chk("setup_psel", 64'(psel), 64'd1);
    chk("setup_penable", 64'(penable), 64'd0);
    chk("setup_paddr", 64'(paddr), 64'(v.addr));
    chk("setup_pwrite", 64'(pwrite), 64'(v.wr));
    if (v.wr) chk("setup_pwdata", 64'(pwdata), 64'(v.wdata));
    for (int w = 0; w <= v.waits; w++) begin
      @(negedge pclk);
      pready  = (w == v.waits);
      prdata  = v.prd;
      pslverr = v.slverr;
      chk("access_penable", 64'(penable), 64'd1);
      chk("access_paddr", 64'(paddr), 64'(v.addr));
    end
    @(negedge pclk);
    pready  = 1'b0;
    pslverr = 1'b0;
    chk("rsp_valid", 64'(rsp_valid), 64'(v.exp_vld));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(v.exp_rdata));
    chk("rsp_err", 64'(rsp_err), 64'(v.exp_err));
    chk("idle_psel", 64'(psel), 64'd0);
    @(negedge pclk);
    chk("rsp_pulse_end", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    vecs[0] = '{0, 1'b1, 32'h10, 32'hA5A5_0001, 32'h0,         0, 1'b0, 4'b0001, 32'h0,         1'b0};
    vecs[1] = '{2, 1'b0, 32'h20, 32'h0,         32'hDEAD_BEEF, 3, 1'b0, 4'b0100, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1, 1'b1, 32'h30, 32'h1234_5678, 32'h55,        0, 1'b1, 4'b0010, 32'hDEAD_BEEF, 1'b1};
    vecs[3] = '{3, 1'b0, 32'h44, 32'h0,         32'hCAFE_0003, 1, 1'b1, 4'b1000, 32'hCAFE_0003, 1'b1};
    vecs[4] = '{0, 1'b0, 32'h0,  32'h0,         32'h1,         0, 1'b0, 4'b0001, 32'h1,         1'b0};

    prst = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    #7;
    chk("rst_psel", 64'(psel), 64'd0);
    chk("rst_penable", 64'(penable), 64'd0);
    chk("rst_pwrite", 64'(pwrite), 64'd0);
    chk("rst_paddr", 64'(paddr), 64'd0);
    chk("rst_pwdata", 64'(pwdata), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    @(negedge pclk);
    prst = 1'b1;

    for (int i = 0; i < 5; i++) do_xfer(vecs[i]);

`ifdef APB_TIMEOUT_EN
    begin
      int acc_cnt;
      acc_cnt = 0;
      @(negedge pclk);
      req_valid = 4'b0010; req_write[1] = 1'b0; req_addr[1*AW +: AW] = 32'h80;
      #1 chk("to_req_ready", 64'(req_ready), 64'b0010);
      @(negedge pclk);
      req_valid = '0;
      for (int c = 0; c < 40; c++) begin
        @(negedge pclk);
        if (!penable) break;
        acc_cnt++;
      end
      chk("to_access_cycles", 64'(acc_cnt), 64'd16);
      chk("to_psel", 64'(psel), 64'd0);
      chk("to_rsp_valid", 64'(rsp_valid), 64'b0010);
      chk("to_rsp_err", 64'(rsp_err), 64'd1);
      chk("to_rsp_rdata", 64'(rsp_rdata), 64'd0);
    end
`endif

    // Reset while ACCESS is waiting on pready; the pointer is at requester 2 beforehand.
    @(negedge pclk);
    req_valid = 4'b0100; req_write[2] = 1'b0; req_addr[2*AW +: AW] = 32'h60;
    @(negedge pclk);
    req_valid = '0;
    pready = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    chk("pre_rst_penable", 64'(penable), 64'd1);
    #2 prst = 1'b0;
    #1;
    chk("arst_psel", 64'(psel), 64'd0);
    chk("arst_penable", 64'(penable), 64'd0);
    chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge pclk);
    prst = 1'b1;
    @(negedge pclk);
    chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);

    // Round-robin with all requesters held, pready always high.
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = 32'h100 + 32'(i * 4);
      req_write[i] = 1'b1;
      req_wdata[i*DW +: DW] = 32'hB000_0000 + 32'(i);
    end
    pready = 1'b1;
    @(negedge pclk);
    req_valid = 4'b1111;
    #1 chk("rr_first_grant", 64'(req_ready), 64'b0001);
    for (int k = 0; k < 5; k++) begin
      @(negedge pclk);
      chk("rr_setup_psel", 64'(psel), 64'd1);
      chk("rr_setup_penable", 64'(penable), 64'd0);
      chk("rr_setup_paddr", 64'(paddr), 64'(32'h100 + 32'((k % 4) * 4)));
      chk("rr_setup_ready", 64'(req_ready), 64'd0);
      chk("rr_prev_rsp", 64'(rsp_valid), (k == 0) ? 64'd0 : 64'(4'b0001 << ((k - 1) % 4)));
      @(negedge pclk);
      if (k == 4) req_valid = '0;
      #1;
      chk("rr_access_penable", 64'(penable), 64'd1);
      chk("rr_next_grant", 64'(req_ready), (k < 4) ? 64'(4'b0001 << ((k + 1) % 4)) : 64'd0);
    end
    @(negedge pclk);
    pready = 1'b0;
    chk("rr_last_rsp", 64'(rsp_valid), 64'b0001);
    chk("rr_end_psel", 64'(psel), 64'd0);
    chk("rr_end_penable", 64'(penable), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
